// File: rtl/wb_regfile.sv
// Writeback stage: picks the ALU or memory result, commits it to the register
// file, serves two combinational decode read ports with write-first bypass.
module wb_regfile #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rfweW,
  input  logic          mtorfselW,
  input  logic [DW-1:0] aluoutW,
  input  logic [DW-1:0] dmrdW,
  input  logic [AW-1:0] rtdW,
  input  logic [AW-1:0] ra1D,
  input  logic [AW-1:0] ra2D,
  output logic [DW-1:0] rd1D,
  output logic [DW-1:0] rd2D,
  output logic [DW-1:0] resultW,
  output logic [31:0]   wbcnt
);

  logic [DW-1:0] r_regs [NREG];
  logic [31:0]   r_wbcnt;
  logic          w_commit;

  assign resultW  = mtorfselW ? dmrdW : aluoutW;
  assign w_commit = rst_n & rfweW & (rtdW != '0);
  assign wbcnt    = r_wbcnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_wbcnt <= '0;
    end else if (w_commit) begin
      r_regs[rtdW] <= resultW;
      r_wbcnt      <= r_wbcnt + 32'd1;
    end
  end

  // Bypass is qualified by rfweW alone so the decode stage sees the value
  // being written this cycle, even while reset suppresses the actual update.
  function automatic logic [DW-1:0] rd_port(input logic [AW-1:0] a);
    if (a == '0)                 return '0;
    else if (rfweW && rtdW == a) return resultW;
    else                         return r_regs[a];
  endfunction

  always_comb begin
    rd1D = rd_port(ra1D);
    rd2D = rd_port(ra2D);
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed + randomized bench for wb_regfile against an array-based model of
// the architectural register file and commit counter.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst_n, rfweW, mtorfselW;
  logic [31:0] aluoutW, dmrdW;
  logic [4:0]  rtdW, ra1D, ra2D;
  logic [31:0] rd1D, rd2D, resultW, wbcnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;

  wb_regfile dut (
    .clk(clk), .rst_n(rst_n), .rfweW(rfweW), .mtorfselW(mtorfselW),
    .aluoutW(aluoutW), .dmrdW(dmrdW), .rtdW(rtdW), .ra1D(ra1D), .ra2D(ra2D),
    .rd1D(rd1D), .rd2D(rd2D), .resultW(resultW), .wbcnt(wbcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_res();
    return mtorfselW ? dmrdW : aluoutW;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (rfweW && rtdW == a) return m_res();
    return m_regs[a];
  endfunction

  // One cycle: drive at negedge, check combinational outputs, clock, check counter.
  task automatic step(input logic rst, input logic we, input logic sel,
                      input logic [31:0] alu, input logic [31:0] dm,
                      input logic [4:0] rtd, input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    rst_n = rst; rfweW = we; mtorfselW = sel; aluoutW = alu; dmrdW = dm;
    rtdW = rtd; ra1D = a1; ra2D = a2;
    #1;
    chk("resultW", resultW, m_res());
    chk("rd1D", rd1D, m_read(a1));
    chk("rd2D", rd2D, m_read(a2));
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_cnt = 32'h0;
    end else if (we && rtd != 0) begin
      m_regs[rtd] = sel ? dm : alu;
      m_cnt = m_cnt + 32'd1;
    end
    #1;
    chk("wbcnt", wbcnt, m_cnt);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_cnt = 32'h0;
    rst_n = 1'b0; rfweW = 1'b0; mtorfselW = 1'b0; aluoutW = '0; dmrdW = '0;
    rtdW = '0; ra1D = '0; ra2D = '0;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd31);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd31);
    chk("rst_wbcnt", wbcnt, 32'h0);

    // Reset clears a written register
    step(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 5'd5, 5'd5, 5'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
    chk("r5_written", rd1D, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
    chk("r5_after_rst", rd1D, 32'h0);
    chk("cnt_after_rst", wbcnt, 32'h0);

    // Result select
    step(1'b1, 1'b1, 1'b0, 32'h1234, 32'hABCD, 5'd3, 5'd0, 5'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3);
    chk("sel_alu", rd1D, 32'h1234);
    step(1'b1, 1'b1, 1'b1, 32'h1234, 32'hABCD, 5'd3, 5'd0, 5'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3);
    chk("sel_dm", rd2D, 32'hABCD);
    chk("sel_cnt", wbcnt, 32'd2);

    // r0 guard: same cycle and next
    step(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd0);
    chk("r0_cnt", wbcnt, 32'd2);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    chk("r0_next", rd1D, 32'h0);

    // Bypass, then old value without bypass
    step(1'b1, 1'b1, 1'b0, 32'h11, 32'h0, 5'd7, 5'd1, 5'd1);
    @(negedge clk);
    rfweW = 1'b1; mtorfselW = 1'b0; aluoutW = 32'h55; rtdW = 5'd7; ra1D = 5'd7; ra2D = 5'd7;
    #1;
    chk("byp_rd1", rd1D, 32'h55);
    chk("byp_rd2", rd2D, 32'h55);
    rfweW = 1'b0;
    #1;
    chk("nobyp_rd1", rd1D, 32'h11);
    chk("nobyp_rd2", rd2D, 32'h11);

    // Write/reset collision
    step(1'b1, 1'b1, 1'b0, 32'h99, 32'h0, 5'd9, 5'd0, 5'd0);
    step(1'b0, 1'b1, 1'b0, 32'h77, 32'h0, 5'd9, 5'd9, 5'd0);
    chk("coll_cnt", wbcnt, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9);
    chk("coll_r9", rd1D, 32'h0);

    // Counter wrap
    @(negedge clk);
    rfweW = 1'b0;
    force dut.r_wbcnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_wbcnt;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    chk("wrap_pre", wbcnt, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 1'b0, 32'h5, 32'h0, 5'd4, 5'd0, 5'd0);
    chk("wrap_post", wbcnt, 32'h0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      logic [4:0] rt;
      rt = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      step(($urandom_range(0, 24) != 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           $urandom, $urandom, rt,
           ($urandom_range(0, 2) == 0) ? rt : 5'($urandom), 5'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
